fd_queue: RTL and testbench
===========================

FD_QUEUE -- requirements
Module: fd_queue

Interface
REQ-001 The module SHALL take parameter IW, default 32, the instruction width.
REQ-002 The module SHALL take parameter PW, default 32, the PC+4 width.
REQ-003 The module SHALL take parameter DEPTH, default 4, the queue entries; legal values are powers of two, 2..16.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port pushF, input, 1: fetch presents a valid instruction this cycle.
REQ-007 Port instrF, input, IW: instruction from fetch.
REQ-008 Port pcplus4F, input, PW: PC+4 from fetch.
REQ-009 Port readyF, output, 1: queue can accept a push this cycle.
REQ-010 Port stallD, input, 1: decode does not consume the head this cycle.
REQ-011 Port flushD, input, 1: branch taken or jump; discard all queued instructions.
REQ-012 Port instrD, output, IW: head instruction, or 0 (bubble) when empty.
REQ-013 Port pcplus4D, output, PW: head PC+4, or 0 when empty.
REQ-014 Port validD, output, 1: head entry is valid.
REQ-015 Port countQ, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular buffer of {instr, pcplus4}, with read pointer rp, write pointer wp (each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0), and occupancy count.
REQ-017 readyF SHALL equal (count != DEPTH); it is combinational from registered state only and does not depend on stallD or flushD.
REQ-018 A push SHALL be accepted iff pushF && readyF && !flushD: the entry is written at wp, and wp increments.
REQ-019 A pop SHALL occur iff validD && !stallD && !flushD: rp increments.
REQ-020 The count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-021 When full, a same-cycle pop SHALL NOT enable a push; pushF with readyF=0 is dropped, and fetch must hold and retry.
REQ-022 When empty, a push SHALL be visible on instrD/validD the following cycle; there is no same-cycle bypass, so latency is 1 cycle.
REQ-023 validD SHALL equal (count != 0); instrD and pcplus4D SHALL be the entry at rp when validD=1, and all zeros otherwise.
REQ-024 flushD=1 SHALL, at the next edge, set rp=wp=0 and count=0, regardless of pushF and stallD; flush has priority over everything.
REQ-025 During the flush cycle, the outputs SHALL still show the pre-flush head, and no pop SHALL be counted.
REQ-026 Stored entry contents SHALL NOT be cleared by flush or reset; only the pointers and count are.
REQ-027 Pointer wrap SHALL be seamless: the order is preserved across the DEPTH-1 -> 0 boundary.
REQ-028 Occupancy SHALL never exceed DEPTH or go below 0 under any input sequence.

Reset
REQ-029 When reset=0, rp, wp and count SHALL clear immediately (asynchronously), giving readyF=1, validD=0, instrD=0, pcplus4D=0 and countQ=0.
REQ-030 Reset assertion mid-operation SHALL discard all entries; the first push after release SHALL be the next head.
REQ-031 Release SHALL take effect on the first rising clk edge with reset=1; a push on that edge is accepted.

Verification
REQ-032 Reset, then push 0x20080005/0x00000004 with stallD=0 -> the next cycle shows validD=1, instrD=0x20080005, pcplus4D=4, countQ=1; the following cycle, with no push, shows validD=0 and instrD=0.
REQ-033 With stallD=1, push 5 instructions at DEPTH=4 -> countQ=4 and readyF=0 after the 4th; the 5th is dropped; releasing stallD drains the 4 in order over 4 cycles.
REQ-034 Full queue, pushF=1 and a pop in the same cycle -> count drops to 3, the push is not accepted, and readyF=1 the next cycle.
REQ-035 count=2 with rp=3, then push and pop concurrently for 6 cycles -> count stays 2 and the output order matches the push order across the wrap.
REQ-036 count=3, flushD=1 with pushF=1 -> the next cycle shows count=0, validD=0, instrD=0, and the pushed instruction is discarded.
REQ-037 Assert reset=0 asynchronously mid-cycle with count=3 -> validD=0 and countQ=0 before the next edge; a push on the first edge after release is seen as the head.

Source files
------------

// File: rtl/fd_queue.sv
// Fetch/decode decoupling queue: a DEPTH-entry circular buffer of {instr, pcplus4}
// sitting between fetch and decode, with a one-cycle push-to-head latency.
module fd_queue #(
   parameter int unsigned IW    = 32,
   parameter int unsigned PW    = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pushF,
   input  logic [IW-1:0]            instrF,
   input  logic [PW-1:0]            pcplus4F,
   output logic                     readyF,
   input  logic                     stallD,
   input  logic                     flushD,
   output logic [IW-1:0]            instrD,
   output logic [PW-1:0]            pcplus4D,
   output logic                     validD,
   output logic [$clog2(DEPTH):0]   countQ
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = IW + PW;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] rp_q, rp_d;
   logic [AW-1:0] wp_q, wp_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   logic [EW-1:0] head;

   assign readyF = (count_q != CW'(DEPTH));
   assign validD = (count_q != '0);
   assign countQ = count_q;

   // Flush gates both handshakes so neither pointer moves on a flush cycle.
   assign push = pushF && readyF && !flushD;
   assign pop  = validD && !stallD && !flushD;

   assign head     = mem_q[rp_q];
   assign instrD   = validD ? head[EW-1:PW] : '0;
   assign pcplus4D = validD ? head[PW-1:0]  : '0;

   always_comb begin
      rp_d    = rp_q;
      wp_d    = wp_q;
      count_d = count_q;
      if (flushD) begin
         rp_d    = '0;
         wp_d    = '0;
         count_d = '0;
      end else begin
         if (pop) begin
            rp_d = rp_q + AW'(1);
         end
         if (push) begin
            wp_d = wp_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rp_q    <= '0;
         wp_q    <= '0;
         count_q <= '0;
      end else begin
         rp_q    <= rp_d;
         wp_q    <= wp_d;
         count_q <= count_d;
      end
   end

   // Entry storage is never cleared; validity is tracked purely by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wp_q] <= {instrF, pcplus4F};
      end
   end

endmodule

// File: tb/tb_fd_queue.sv
// Directed bench for fd_queue: a queue model holds expected entries, popped and
// compared whenever decode consumes the head.
module tb_fd_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        pushF;
   logic [31:0] instrF;
   logic [31:0] pcplus4F;
   logic        readyF;
   logic        stallD;
   logic        flushD;
   logic [31:0] instrD;
   logic [31:0] pcplus4D;
   logic        validD;
   logic [2:0]  countQ;

   int checks   = 0;
   int failures = 0;
   logic [63:0] sb[$];

   fd_queue #(.IW(32), .PW(32), .DEPTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .pushF    (pushF),
      .instrF   (instrF),
      .pcplus4F (pcplus4F),
      .readyF   (readyF),
      .stallD   (stallD),
      .flushD   (flushD),
      .instrD   (instrD),
      .pcplus4D (pcplus4D),
      .validD   (validD),
      .countQ   (countQ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check visible state against the model, advance.
   task automatic cycle(input logic p, input logic [31:0] i, input logic [31:0] pc,
                        input logic st, input logic fl);
      int          n;
      logic        mpush, mpop;
      logic [63:0] head;
      pushF = p; instrF = i; pcplus4F = pc; stallD = st; flushD = fl;
      n = sb.size();
      #1;
      chk("readyF", 64'(readyF), 64'(n != 4));
      chk("validD", 64'(validD), 64'(n != 0));
      chk("countQ", 64'(countQ), 64'(n));
      mpop  = (n != 0) && !st && !fl;
      mpush = p && (n != 4) && !fl;
      if (n == 0) begin
         chk("bubble_instr", 64'(instrD), 64'd0);
         chk("bubble_pc", 64'(pcplus4D), 64'd0);
      end else begin
         if (mpop) head = sb.pop_front();
         else      head = sb[0];
         chk("head_instr", 64'(instrD), 64'(head[63:32]));
         chk("head_pc", 64'(pcplus4D), 64'(head[31:0]));
      end
      if (fl) sb.delete();
      else if (mpush) sb.push_back({i, pc});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; pushF = 1'b0; instrF = '0; pcplus4F = '0; stallD = 1'b0; flushD = 1'b0;
      @(posedge clk); #1;
      chk("rst_ready", 64'(readyF), 64'd1);
      chk("rst_valid", 64'(validD), 64'd0);
      chk("rst_count", 64'(countQ), 64'd0);
      chk("rst_instr", 64'(instrD), 64'd0);
      reset = 1'b1;

      // Single push, one-cycle latency, then drains.
      cycle(1'b1, 32'h2008_0005, 32'h4, 1'b0, 1'b0);
      chk("v32_instr", 64'(instrD), 64'h2008_0005);
      chk("v32_pc", 64'(pcplus4D), 64'h4);
      chk("v32_count", 64'(countQ), 64'd1);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("v32_empty_valid", 64'(validD), 64'd0);
      chk("v32_empty_instr", 64'(instrD), 64'd0);

      // Fill under stall, fifth push dropped, then drain in order.
      for (int k = 0; k < 5; k++) cycle(1'b1, 32'hA000_0000 + k, 32'h100 + 4 * k, 1'b1, 1'b0);
      chk("full_count", 64'(countQ), 64'd4);
      chk("full_ready", 64'(readyF), 64'd0);
      // Full with a pop and a push in the same cycle: push must be dropped.
      cycle(1'b1, 32'hDEAD_0001, 32'h999, 1'b0, 1'b0);
      chk("fullpop_count", 64'(countQ), 64'd3);
      chk("fullpop_ready", 64'(readyF), 64'd1);
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Move rp to 3 with count 2, then stream across the wrap.
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) cycle(1'b1, 32'hB000_0000 + k, 32'h200 + 4 * k, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) cycle(1'b1, 32'hC000_0000 + k, 32'h300 + 4 * k, 1'b1, 1'b0);
      for (int k = 2; k < 8; k++) begin
         cycle(1'b1, 32'hC000_0000 + k, 32'h300 + 4 * k, 1'b0, 1'b0);
         chk("wrap_count", 64'(countQ), 64'd2);
      end

      // Flush with count 3 and a concurrent push.
      cycle(1'b1, 32'hC000_0008, 32'h320, 1'b1, 1'b0);
      chk("preflush_count", 64'(countQ), 64'd3);
      cycle(1'b1, 32'hEEEE_0000, 32'h400, 1'b0, 1'b1);
      chk("flush_count", 64'(countQ), 64'd0);
      chk("flush_valid", 64'(validD), 64'd0);
      chk("flush_instr", 64'(instrD), 64'd0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Asynchronous reset mid-cycle with count 3.
      for (int k = 0; k < 3; k++) cycle(1'b1, 32'hD000_0000 + k, 32'h500 + 4 * k, 1'b1, 1'b0);
      pushF = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_valid", 64'(validD), 64'd0);
      chk("arst_count", 64'(countQ), 64'd0);
      chk("arst_instr", 64'(instrD), 64'd0);
      chk("arst_ready", 64'(readyF), 64'd1);
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      cycle(1'b1, 32'hF00D_0001, 32'h600, 1'b1, 1'b0);
      chk("post_rst_head", 64'(instrD), 64'hF00D_0001);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
